// File: rtl/rst_seq_pkg.sv
// ======================================================================
// rst_seq_pkg -- state encoding and default sizing for rst_seq_ctrl.
// Rev 1.0
// ======================================================================
`default_nettype none

package rst_seq_pkg;

   localparam int DEF_STAGE_N     = 4;
   localparam int DEF_DLY_W       = 8;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      ST_HOLD = 3'd0,
      ST_WAIT = 3'd1,
      ST_REL  = 3'd2,
      ST_EN   = 3'd3,
      ST_RUN  = 3'd4,
      ST_GATE = 3'd5,
      ST_ASRT = 3'd6,
      ST_HELD = 3'd7
   } seq_state_e;

   function automatic logic is_busy(input seq_state_e s);
      return s inside {ST_WAIT, ST_REL, ST_EN, ST_GATE, ST_ASRT};
   endfunction

endpackage

`default_nettype wire

// File: rtl/rst_sync.sv
// ======================================================================
// rst_sync -- reset synchronizer: asynchronous assertion, synchronous release.
// Rev 1.0
// ======================================================================
`default_nettype none

module rst_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic arst_n,
   output logic rst_sync_n
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
// ======================================================================
// rst_seq_ctrl -- staged reset release sequencer; soft reset via RST_SEQ_SOFT_EN.
// Rev 1.0
// ======================================================================
`default_nettype none

module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int STAGE_N     = DEF_STAGE_N,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DLY_W       = DEF_DLY_W
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [STAGE_N*DLY_W-1:0] stage_dly,
   input  logic                     soft_rst_req,
   output logic                     soft_rst_ack,
   output logic [STAGE_N-1:0]       stage_rst_n,
   output logic [STAGE_N-1:0]       stage_clk_en,
   output logic                     seq_busy,
   output logic                     seq_done
);

   localparam int             K_W    = (STAGE_N > 1) ? $clog2(STAGE_N) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(STAGE_N - 1);

   logic               rst_sync_n;
   seq_state_e         state_q, state_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [DLY_W-1:0]   cnt_q, cnt_d;
   logic [STAGE_N-1:0] rst_n_q, rst_n_d;
   logic [STAGE_N-1:0] clk_en_q, clk_en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ack_q, ack_d;

   rst_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rst_sync (
      .clk        (clk),
      .arst_n     (reset_n),
      .rst_sync_n (rst_sync_n)
   );

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_q  <= ST_HOLD;
         k_q      <= '0;
         cnt_q    <= '0;
         rst_n_q  <= '0;
         clk_en_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         cnt_q    <= cnt_d;
         rst_n_q  <= rst_n_d;
         clk_en_q <= clk_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ack_q    <= ack_d;
      end
   end

   // The final stage skips EN so RUN (and seq_done) coincide with its clock enable.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_HOLD: begin
            if (rst_sync_n) begin
               state_d = ST_WAIT;
               k_d     = '0;
               cnt_d   = stage_dly[0 +: DLY_W];
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_REL;
            end else begin
               cnt_d = cnt_q - DLY_W'(1);
            end
         end
         ST_REL: begin
            state_d = (k_q == K_LAST) ? ST_RUN : ST_EN;
         end
         ST_EN: begin
            if (k_q == K_LAST) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_WAIT;
               k_d     = k_q + K_W'(1);
               cnt_d   = stage_dly[int'(k_d)*DLY_W +: DLY_W];
            end
         end
`ifdef RST_SEQ_SOFT_EN
         ST_RUN: begin
            if (soft_rst_req) begin
               state_d = ST_GATE;
            end
         end
         ST_GATE: begin
            state_d = ST_ASRT;
            k_d     = K_LAST;
         end
         ST_ASRT: begin
            if (k_q == '0) begin
               state_d = ST_HELD;
            end else begin
               k_d = k_q - K_W'(1);
            end
         end
         ST_HELD: begin
            if (!soft_rst_req) begin
               state_d = ST_WAIT;
               k_d     = '0;
               cnt_d   = stage_dly[0 +: DLY_W];
            end
         end
`else
         ST_RUN: begin
            state_d = ST_RUN;
         end
`endif
         default: begin
            state_d = ST_HOLD;
            k_d     = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the transition so every output is a flop.
   always_comb begin
      rst_n_d  = rst_n_q;
      clk_en_d = clk_en_q;
      busy_d   = is_busy(state_d);
      done_d   = (state_d == ST_RUN);
      if (state_d == ST_HOLD) begin
         rst_n_d  = '0;
         clk_en_d = '0;
      end
      if (state_d == ST_REL) begin
         rst_n_d = rst_n_q | (STAGE_N'(1) << k_q);
      end
      if ((state_d == ST_EN) || ((state_d == ST_RUN) && (state_q == ST_REL))) begin
         clk_en_d = clk_en_q | (STAGE_N'(1) << k_q);
      end
`ifdef RST_SEQ_SOFT_EN
      if (state_d == ST_GATE) begin
         clk_en_d = '0;
      end
      if (state_d == ST_ASRT) begin
         rst_n_d = rst_n_q & ~(STAGE_N'(1) << k_d);
      end
      ack_d = (state_d == ST_HELD) && soft_rst_req;
`else
      ack_d = 1'b0;
`endif
   end

`ifndef RST_SEQ_SOFT_EN
   logic unused_soft_req;
   assign unused_soft_req = soft_rst_req;
`endif

   assign stage_rst_n  = rst_n_q;
   assign stage_clk_en = clk_en_q;
   assign seq_busy     = busy_q;
   assign seq_done     = done_q;
   assign soft_rst_ack = ack_q;

endmodule

`default_nettype wire
